// File: rtl/dct_pkg.sv
// Shared definitions for the 8-point DCT row stage.
// Holds the operand/accumulator widths, the row length, the state encoding
// of the row sequencer, the 64-entry cosine weight table and the
// round-and-saturate helper that turns an accumulated sum into a coefficient.
package dct_pkg;

  localparam int DW      = 16;          // sample / coefficient / operand width
  localparam int FRAC    = 14;          // fractional bits of the cosine table
  localparam int AW      = 2 * DW + 3;  // accumulator: product width + 3 guard bits
  localparam int ROW_LEN = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  // ROM[k][n] = round(2^14 * 0.5 * c(k) * cos((2n+1)k*pi/16)), flattened as {k, n}.
  localparam logic signed [DW-1:0] COS_TAB [64] = '{
    16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,
    16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035,
    16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568,
    16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811,
    16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,
    16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551,
    16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135,
    16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598
  };

  localparam logic signed [AW-1:0] ROUND_HALF = AW'(2 ** (FRAC - 1));
  localparam logic signed [AW-1:0] COEF_MAX   = AW'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-1:0] COEF_MIN   = -(AW'(2 ** (DW - 1)));

  // Round half up (add half an LSB, then floor via arithmetic shift) and
  // clamp into the signed DW-bit range.
  function automatic logic signed [DW-1:0] round_sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] r;
    r = (acc + ROUND_HALF) >>> FRAC;
    if (r > COEF_MAX) begin
      round_sat = COEF_MAX[DW-1:0];
    end else if (r < COEF_MIN) begin
      round_sat = COEF_MIN[DW-1:0];
    end else begin
      round_sat = r[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/dct_cos_rom.sv
// Combinational cosine weight lookup for the DCT row stage.
// Ports:
//   k      - coefficient index (row of the table)
//   n      - sample index (column of the table)
//   weight - signed Q1.14 weight C[k][n]
module dct_cos_rom
  import dct_pkg::*;
(
  input  logic [2:0]           k,
  input  logic [2:0]           n,
  output logic signed [DW-1:0] weight
);

  assign weight = COS_TAB[{k, n}];

endmodule

// File: rtl/dct_row_mac.sv
// Row sequencer and accumulator feeding an external multiplier for the
// 8-point 1D DCT row stage. A row of 8 samples is loaded, then for each
// k = 0..7 the 8 products x[n]*C[k][n] are requested one at a time,
// accumulated, rounded, saturated and presented downstream.
// Ports:
//   clk, clr_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - sample input handshake, in_sample in row order
//   mul_start           - one-cycle launch pulse to the multiplier
//   mul_a, mul_b        - operands x[n] and C[k][n], held until mul_done
//   mul_done, mul_prod  - multiplier completion and signed product
//   out_valid/out_ready - coefficient output handshake
//   out_coef, out_idx   - coefficient y[k] and its index k
//   state               - current sequencer state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its data stable while valid && !ready, and
// valid never drops without a transfer (except by reset).
module dct_row_mac
  import dct_pkg::*;
(
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DW-1:0]   in_sample,
  output logic                   mul_start,
  output logic signed [DW-1:0]   mul_a,
  output logic signed [DW-1:0]   mul_b,
  input  logic                   mul_done,
  input  logic signed [2*DW-1:0] mul_prod,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [DW-1:0]   out_coef,
  output logic [2:0]             out_idx,
  output state_t                 state
);

  logic signed [DW-1:0] sample_buf [ROW_LEN];
  logic [2:0]           n_q;
  logic [2:0]           k_q;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_sum;
  logic signed [DW-1:0] rom_weight;
  logic                 load_fire;
  logic                 done_fire;

  dct_cos_rom u_rom (
    .k      (k_q),
    .n      (n_q),
    .weight (rom_weight)
  );

  assign load_fire = (state == LOAD) && in_valid && in_ready;
  // mul_start is high only in the first WAIT cycle; a done seen in that
  // cycle belongs to nothing we launched and is ignored.
  assign done_fire = (state == WAIT) && mul_done && !mul_start;
  assign acc_sum   = acc_q + AW'(mul_prod);

  // Sample storage carries no reset: it is always fully rewritten in LOAD
  // before it is read.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      sample_buf[n_q] <= in_sample;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= LOAD;
      in_ready  <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_idx   <= '0;
      acc_q     <= '0;
      n_q       <= '0;
      k_q       <= '0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (load_fire) begin
            if (n_q == 3'd7) begin
              n_q      <= '0;
              k_q      <= '0;
              acc_q    <= '0;
              in_ready <= 1'b0;
              state    <= ISSUE;
            end else begin
              n_q <= n_q + 3'd1;
            end
          end
        end
        ISSUE: begin
          mul_a     <= sample_buf[n_q];
          mul_b     <= rom_weight;
          mul_start <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (done_fire) begin
            acc_q <= acc_sum;
            if (n_q != 3'd7) begin
              n_q   <= n_q + 3'd1;
              state <= ISSUE;
            end else begin
              // Final term: register the finished coefficient directly from
              // the updated sum so it appears together with out_valid.
              out_coef  <= round_sat(acc_sum);
              out_idx   <= k_q;
              out_valid <= 1'b1;
              state     <= OUT;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            n_q       <= '0;
            if (k_q != 3'd7) begin
              k_q   <= k_q + 3'd1;
              acc_q <= '0;
              state <= ISSUE;
            end else begin
              in_ready <= 1'b1;
              state    <= LOAD;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_row_mac.sv
// Self-checking bench for dct_row_mac: a behavioural multiplier with
// programmable latency, a floating-point DCT reference model and an
// expected-coefficient queue.
module tb_dct_row_mac;
  import dct_pkg::*;

  // ---------------- clock / reset ----------------
  logic                   clk;
  logic                   clr_n;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [DW-1:0]   in_sample;
  logic                   mul_start;
  logic signed [DW-1:0]   mul_a;
  logic signed [DW-1:0]   mul_b;
  logic                   mul_done;
  logic signed [2*DW-1:0] mul_prod;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [DW-1:0]   out_coef;
  logic [2:0]             out_idx;
  state_t                 state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  dct_row_mac dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sample (in_sample),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_prod  (mul_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_idx   (out_idx),
    .state     (state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam real PI = 3.14159265358979323846;

  function automatic longint cos_weight(input int k, input int n);
    real ck;
    real v;
    ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v  = 16384.0 * 0.5 * ck * $cos(real'((2 * n + 1) * k) * PI / 16.0);
    if (v >= 0.0) return longint'($floor(v + 0.5));
    else          return -longint'($floor(-v + 0.5));
  endfunction

  task automatic model_row(input logic signed [DW-1:0] x [8], output logic [DW-1:0] y [8]);
    for (int k = 0; k < 8; k++) begin
      longint s;
      longint r;
      s = 0;
      for (int n = 0; n < 8; n++) s += longint'(x[n]) * cos_weight(k, n);
      r = longint'($floor((real'(s) + 8192.0) / 16384.0));
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      y[k] = r[DW-1:0];
    end
  endtask

  // ---------------- multiplier model ----------------
  int mul_lat  = 1;
  bit spur_en  = 1'b0;
  bit mul_busy = 1'b0;
  int mul_err  = 0;

  initial begin
    logic signed [DW-1:0] a_l;
    logic signed [DW-1:0] b_l;
    int cnt;
    mul_done = 1'b0;
    mul_prod = '0;
    forever begin
      @(posedge clk); #1;
      if (clr_n && mul_start) begin
        mul_busy = 1'b1;
        a_l = mul_a;
        b_l = mul_b;
        // Garbage completion during the launch cycle must be ignored.
        if (spur_en) begin
          mul_done = 1'b1;
          mul_prod = 32'($urandom);
        end
        cnt = 0;
        while (cnt < mul_lat && clr_n) begin
          @(posedge clk); #1;
          mul_done = 1'b0;
          cnt++;
          if (clr_n) begin
            if (mul_start) mul_err++;
            if (mul_a !== a_l || mul_b !== b_l) mul_err++;
          end
        end
        if (clr_n) begin
          mul_done = 1'b1;
          mul_prod = 32'(longint'(a_l) * longint'(b_l));
          @(posedge clk); #1;
          mul_done = 1'b0;
        end
        mul_done = 1'b0;
        mul_busy = 1'b0;
      end
    end
  end

  // Counts every accepted sample.
  int accepts = 0;
  always @(posedge clk) begin
    if (clr_n && in_valid && in_ready) accepts++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_row(input logic signed [DW-1:0] x [8]);
    int n;
    int guard;
    bit taken;
    n = 0;
    guard = 0;
    while (n < 8 && guard < 2000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sample = in_valid ? x[n] : DW'($urandom);
      taken     = in_valid && in_ready;
      @(negedge clk);
      if (taken) n++;
      guard++;
    end
    if (n < 8) check("send_timeout", n, 8);
    // Keep offering junk while the row is computed; none may be accepted.
    in_valid  = 1'b1;
    in_sample = DW'($urandom);
  endtask

  task automatic recv_coef(input int idx, input logic [DW-1:0] exp, input bit stall);
    int guard;
    int hold_err;
    logic [DW-1:0] c0;
    logic [2:0] i0;
    guard = 0;
    hold_err = 0;
    out_ready = 1'b0;
    while (!out_valid && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      check($sformatf("out_valid_timeout_k%0d", idx), 0, 1);
      return;
    end
    if (idx == 7) in_valid = 1'b0;
    if (stall) begin
      c0 = out_coef;
      i0 = out_idx;
      repeat (10) begin
        @(negedge clk);
        if (!out_valid || out_coef !== c0 || out_idx !== i0 || mul_start || in_ready) hold_err++;
      end
      check("stall_hold", hold_err, 0);
    end else begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    out_ready = 1'b1;
    check($sformatf("coef_k%0d", idx), $signed(out_coef), $signed(exp));
    check($sformatf("idx_k%0d", idx), out_idx, idx);
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("valid_drop_k%0d", idx), out_valid, 0);
    if (idx == 7) check("in_ready_after_row", in_ready, 1);
  endtask

  task automatic run_row(input logic signed [DW-1:0] x [8], input logic [DW-1:0] y [8],
                         input int lat, input bit spur, input int stall_idx, input int stop_after);
    int a0;
    a0 = accepts;
    mul_lat = lat;
    spur_en = spur;
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(y[k]);
    send_row(x);
    for (int k = 0; k < stop_after; k++) recv_coef(k, exp_q.pop_front(), k == stall_idx);
    check("accepts_per_row", accepts - a0, 8);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_in_ready"},  in_ready, 0);
    check({pfx, "_mul_start"}, mul_start, 0);
    check({pfx, "_mul_a"},     mul_a, 0);
    check({pfx, "_mul_b"},     mul_b, 0);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_coef"},  out_coef, 0);
    check({pfx, "_out_idx"},   out_idx, 0);
    check({pfx, "_state"},     int'(state), int'(LOAD));
  endtask

  // ---------------- main sequence ----------------
  logic signed [DW-1:0] x [8];
  logic [DW-1:0]        y [8];

  initial begin
    int g;
    clr_n     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    clr_n = 1'b1;
    check("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_first_edge", in_ready, 1);

    // DC row, slow multiplier
    for (int n = 0; n < 8; n++) begin
      x[n] = 16'sd1000;
      y[n] = '0;
    end
    y[0] = 16'd2829;
    run_row(x, y, 17, 1'b0, -1, 8);

    // Impulse, with spurious done pulses in the launch cycle
    for (int n = 0; n < 8; n++) x[n] = '0;
    x[0] = 16'sd1000;
    model_row(x, y);
    y[0] = 16'd354;
    y[1] = 16'd490;
    run_row(x, y, 3, 1'b1, -1, 8);

    // Positive saturation
    for (int n = 0; n < 8; n++) x[n] = 16'sh7fff;
    model_row(x, y);
    y[0] = 16'h7fff;
    run_row(x, y, 2, 1'b0, -1, 8);

    // Negative saturation
    for (int n = 0; n < 8; n++) x[n] = 16'sh8000;
    model_row(x, y);
    y[0] = 16'h8000;
    run_row(x, y, 1, 1'b1, -1, 8);

    // Backpressure on y[3]
    for (int n = 0; n < 8; n++) x[n] = DW'($urandom);
    model_row(x, y);
    run_row(x, y, $urandom_range(1, 4), 1'b1, 3, 8);

    // Random rows
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 8; n++) begin
        if (r[0]) x[n] = DW'($urandom);
        else      x[n] = DW'($urandom_range(0, 4000)) - 16'sd2000;
      end
      model_row(x, y);
      run_row(x, y, $urandom_range(1, 5), 1'($urandom_range(0, 1)), -1, 8);
    end

    // Reset while waiting on a product for k=4
    for (int n = 0; n < 8; n++) x[n] = DW'($urandom);
    model_row(x, y);
    run_row(x, y, 4, 1'b1, -1, 4);
    g = 0;
    while (state != WAIT && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("reached_wait_k4", int'(state), int'(WAIT));
    in_valid = 1'b0;
    #2 clr_n = 1'b0;
    #1 check_reset_values("midrow");
    @(negedge clk);
    clr_n = 1'b1;
    g = 0;
    while (mul_busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("mul_idle_after_reset", mul_busy, 0);
    for (int n = 0; n < 8; n++) x[n] = DW'($urandom);
    model_row(x, y);
    run_row(x, y, $urandom_range(1, 4), 1'b1, -1, 8);

    check("mul_operand_discipline", mul_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
